uart_tx_fifo_reader: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 34 +++
 rtl/uart_tx_baud_gen.sv | 26 ++
 rtl/uart_tx_fifo_reader.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX FIFO reader.
// The frame length depends on the optional macro UART_TX_PARITY_EN.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam int BYTES_PER_WORD = 4;
  localparam int BIT_IDX_W      = 3;
  localparam int BYTE_IDX_W     = 2;

  localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(7);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Maps the send-order byte index onto the byte lane of the captured word.
  function automatic logic [BYTE_IDX_W-1:0] byte_slot(
    input logic [BYTE_IDX_W-1:0] idx,
    input logic                  msb_first
  );
    return msb_first ? (LAST_BYTE - idx) : idx;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-time generator: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// restart holds the count at zero so every frame starts on a fresh bit boundary.
module uart_tx_baud_gen #(
  parameter int CLK_DIV = 868
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic restart,
  output logic bit_end
);

  localparam logic [15:0] LAST_CNT = 16'(CLK_DIV - 1);

  logic [15:0] baud_cnt;

  assign bit_end = (baud_cnt == LAST_CNT);

  always_ff @(posedge rd_clk) begin
    if (rd_rst || restart || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// Pops 32-bit words from an FWFT FIFO and sends them as four UART frames.
// Define UART_TX_PARITY_EN to add an even-parity bit to each frame.
//
// state  | meaning
// IDLE   | waiting for a word; pops it the cycle fifo_empty is low
// START  | start bit (tx low)
// DATA   | data bits of the current byte, LSB first
// PARITY | even parity of the current byte (UART_TX_PARITY_EN only)
// STOP   | stop bit; next byte or back to IDLE after the last byte
module uart_tx_fifo_reader
  import uart_tx_pkg::*;
#(
  parameter int    CLK_DIV    = 868,
  parameter string BYTE_ORDER = "LSB_FIRST",
  parameter int    DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  localparam logic MSB_FIRST = (BYTE_ORDER == "MSB_FIRST");

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   word_reg;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic [BIT_IDX_W-1:0]    bit_idx;
  logic [BYTE_IDX_W-1:0]   slot;
  logic [7:0]              cur_byte;
  logic                    bit_end;
  logic                    tx_bit;
  logic                    pop_req;
  logic                    done_req;

  uart_tx_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_gen (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .restart (state == IDLE),
    .bit_end (bit_end)
  );

  assign slot     = byte_slot(byte_idx, MSB_FIRST);
  assign cur_byte = word_reg[{slot, 3'b000} +: 8];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_bit     = 1'b1;
    pop_req    = 1'b0;
    done_req   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_req    = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_bit = cur_byte[bit_idx];
        if (bit_end && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_bit = ^cur_byte;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            done_req   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = START;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset gates the strobes in the same cycle so nothing is popped or reported mid-reset.
  assign fifo_rd_en = pop_req & ~rd_rst;
  assign word_done  = done_req & ~rd_rst;
  assign busy       = (state != IDLE) | fifo_rd_en;
  assign tx         = tx_bit;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      word_reg <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
    end else begin
      if (fifo_rd_en) begin
        word_reg <= fifo_rd_data;
        byte_idx <= '0;
        bit_idx  <= '0;
      end
      if (bit_end) begin
        case (state)
          START:   bit_idx  <= '0;
          DATA:    bit_idx  <= bit_idx + BIT_IDX_W'(1);
          STOP:    byte_idx <= byte_idx + BYTE_IDX_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: one LSB_FIRST and one MSB_FIRST instance at CLK_DIV=4.
// Honours UART_TX_PARITY_EN for frame length and the parity scenario.
module tb_uart_tx_fifo_reader;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD_CYC = FB * CD * 4;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  always #5 rd_clk = ~rd_clk;

  // Simple FIFO models, one per DUT; pops take effect at the clock edge.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [3:0]  wa = '0, ra = '0, wb = '0, rb = '0;
  int          pops_a = 0;

  logic        empty_a, empty_b, rd_en_a, rd_en_b;
  logic [31:0] data_a, data_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  assign empty_a = (wa == ra);
  assign empty_b = (wb == rb);
  assign data_a  = mem_a[ra];
  assign data_b  = mem_b[rb];

  always @(posedge rd_clk) begin
    if (rd_en_a === 1'b1) begin
      ra     <= ra + 4'd1;
      pops_a <= pops_a + 1;
    end
    if (rd_en_b === 1'b1) rb <= rb + 4'd1;
  end

  uart_tx_fifo_reader #(.CLK_DIV(CD), .BYTE_ORDER("LSB_FIRST"), .DATA_WIDTH(32)) dut_lsb (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(data_a), .fifo_empty(empty_a),
    .fifo_rd_en(rd_en_a), .tx(tx_a), .busy(busy_a), .word_done(done_a));

  uart_tx_fifo_reader #(.CLK_DIV(CD), .BYTE_ORDER("MSB_FIRST"), .DATA_WIDTH(32)) dut_msb (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(data_b), .fifo_empty(empty_b),
    .fifo_rd_en(rd_en_b), .tx(tx_b), .busy(busy_b), .word_done(done_b));

  int   n_checks = 0;
  int   n_pass   = 0;
  logic tx_s [512];
  logic done_s [512];
  logic busy_s [512];
  logic pop_s [512];
  logic exp_s [512];

  task automatic push_a(input logic [31:0] w);
    mem_a[wa] = w;
    wa = wa + 4'd1;
  endtask

  task automatic push_b(input logic [31:0] w);
    mem_b[wb] = w;
    wb = wb + 4'd1;
  endtask

  // Returns in the pop cycle (rd_en high), or with ok=0 after 50 cycles.
  task automatic wait_pop(input bit sel, output bit ok);
    ok = 1'b0;
    #1;
    for (int i = 0; i < 50; i++) begin
      if ((sel ? rd_en_b : rd_en_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge rd_clk);
    end
  endtask

  // Index 0 is the cycle after the current one.
  task automatic record(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rd_clk);
      tx_s[i]   = sel ? tx_b   : tx_a;
      done_s[i] = sel ? done_b : done_a;
      busy_s[i] = sel ? busy_b : busy_a;
      pop_s[i]  = sel ? rd_en_b : rd_en_a;
    end
  endtask

  // send holds the first transmitted byte in [7:0], the last in [31:24].
  task automatic build_exp(input logic [31:0] send);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      int base;
      b    = send[8*k +: 8];
      base = k * FB * CD;
      for (int c = 0; c < CD; c++) begin
        exp_s[base + c] = 1'b0;
        for (int j = 0; j < 8; j++) exp_s[base + CD*(1+j) + c] = b[j];
        if (FB == 11) exp_s[base + CD*9 + c] = ^b;
        exp_s[base + CD*(FB-1) + c] = 1'b1;
      end
    end
  endtask

  function automatic int stream_errs(input int off);
    int e = 0;
    for (int i = 0; i < WORD_CYC; i++) if (tx_s[off + i] !== exp_s[i]) e++;
    return e;
  endfunction

  function automatic logic [7:0] dec_byte(input int off, input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = tx_s[off + k*FB*CD + CD*(1+j) + CD/2];
    return b;
  endfunction

  function automatic int count_ones(input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (sel == 0 && done_s[i] === 1'b1) c++;
      if (sel == 1 && pop_s[i] === 1'b1) c++;
      if (sel == 2 && busy_s[i] !== 1'b1) c++;
    end
    return c;
  endfunction

  task automatic test_reset();
    rd_rst = 1'b1;
    repeat (3) @(negedge rd_clk);
    n_checks++; if (tx_a !== 1'b1) $display("FAIL reset_tx_lsb: got %b want 1", tx_a); else n_pass++;
    n_checks++; if (rd_en_a !== 1'b0) $display("FAIL reset_rd_en_lsb: got %b want 0", rd_en_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy_lsb: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done_lsb: got %b want 0", done_a); else n_pass++;
    n_checks++; if (tx_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL reset_msb: got tx=%b busy=%b want tx=1 busy=0", tx_b, busy_b); else n_pass++;
    rd_rst = 1'b0;
    @(negedge rd_clk);
  endtask

  task automatic test_lsb_word();
    bit ok;
    logic [31:0] send;
    int e;
    send = 32'h11223344;
    push_a(32'h11223344);
    wait_pop(1'b0, ok);
    n_checks++; if (!ok) begin $display("FAIL lsb_pop: got no pop want pop within 50 cycles"); return; end else n_pass++;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL lsb_busy_pop: got %b want 1", busy_a); else n_pass++;
    record(1'b0, WORD_CYC + 4);
    build_exp(send);
    e = stream_errs(0);
    n_checks++; if (e != 0) $display("FAIL lsb_stream: got %0d bad tx cycles want 0", e); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dec_byte(0, k) !== send[8*k +: 8]) $display("FAIL lsb_byte%0d: got %h want %h", k, dec_byte(0, k), send[8*k +: 8]);
      else n_pass++;
    end
    n_checks++; if (count_ones(1, 0, WORD_CYC + 3) != 0) $display("FAIL lsb_extra_pop: got %0d want 0", count_ones(1, 0, WORD_CYC + 3)); else n_pass++;
    n_checks++; if (done_s[WORD_CYC-1] !== 1'b1 || count_ones(0, 0, WORD_CYC + 3) != 1)
      $display("FAIL lsb_word_done: got done@160=%b pulses=%0d want 1 and 1", done_s[WORD_CYC-1], count_ones(0, 0, WORD_CYC + 3)); else n_pass++;
    n_checks++; if (count_ones(2, 0, WORD_CYC - 1) != 0 || busy_s[WORD_CYC] !== 1'b0)
      $display("FAIL lsb_busy: got low_during=%0d after=%b want 0 and 0", count_ones(2, 0, WORD_CYC - 1), busy_s[WORD_CYC]); else n_pass++;
  endtask

  task automatic test_msb_word();
    bit ok;
    logic [31:0] send;
    int e;
    send = 32'h810FC3A5;
    push_b(32'hA5C30F81);
    wait_pop(1'b1, ok);
    n_checks++; if (!ok) begin $display("FAIL msb_pop: got no pop want pop within 50 cycles"); return; end else n_pass++;
    record(1'b1, WORD_CYC + 2);
    build_exp(send);
    e = stream_errs(0);
    n_checks++; if (e != 0) $display("FAIL msb_stream: got %0d bad tx cycles want 0", e); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dec_byte(0, k) !== send[8*k +: 8]) $display("FAIL msb_byte%0d: got %h want %h", k, dec_byte(0, k), send[8*k +: 8]);
      else n_pass++;
    end
    n_checks++; if (done_s[WORD_CYC-1] !== 1'b1) $display("FAIL msb_word_done: got %b want 1", done_s[WORD_CYC-1]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_a(32'h00000001);
    push_a(32'hFFFFFFFF);
    wait_pop(1'b0, ok);
    n_checks++; if (!ok) begin $display("FAIL b2b_pop: got no pop want pop within 50 cycles"); return; end else n_pass++;
    record(1'b0, 2*WORD_CYC + 4);
    n_checks++; if (pop_s[WORD_CYC] !== 1'b1 || count_ones(1, 0, 2*WORD_CYC + 3) != 1)
      $display("FAIL b2b_second_pop: got pop@gap=%b pops=%0d want 1 and 1", pop_s[WORD_CYC], count_ones(1, 0, 2*WORD_CYC + 3)); else n_pass++;
    n_checks++; if (tx_s[WORD_CYC] !== 1'b1 || tx_s[WORD_CYC+1] !== 1'b0)
      $display("FAIL b2b_gap: got idle=%b start=%b want 1 and 0", tx_s[WORD_CYC], tx_s[WORD_CYC+1]); else n_pass++;
    n_checks++; if (busy_s[WORD_CYC] !== 1'b1) $display("FAIL b2b_busy_gap: got %b want 1", busy_s[WORD_CYC]); else n_pass++;
    n_checks++; if (done_s[WORD_CYC-1] !== 1'b1 || done_s[2*WORD_CYC] !== 1'b1 || count_ones(0, 0, 2*WORD_CYC + 3) != 2)
      $display("FAIL b2b_done: got pulses=%0d want 2 at word ends", count_ones(0, 0, 2*WORD_CYC + 3)); else n_pass++;
    n_checks++; if ({dec_byte(0, 3), dec_byte(0, 2), dec_byte(0, 1), dec_byte(0, 0)} !== 32'h00000001)
      $display("FAIL b2b_word0: got %h want 00000001", {dec_byte(0, 3), dec_byte(0, 2), dec_byte(0, 1), dec_byte(0, 0)}); else n_pass++;
    n_checks++; if ({dec_byte(WORD_CYC+1, 3), dec_byte(WORD_CYC+1, 2), dec_byte(WORD_CYC+1, 1), dec_byte(WORD_CYC+1, 0)} !== 32'hFFFFFFFF)
      $display("FAIL b2b_word1: got %h want ffffffff", {dec_byte(WORD_CYC+1, 3), dec_byte(WORD_CYC+1, 2), dec_byte(WORD_CYC+1, 1), dec_byte(WORD_CYC+1, 0)}); else n_pass++;
  endtask

  task automatic test_empty_idle();
    int pops = 0, txl = 0, bsy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge rd_clk);
      if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) pops++;
      if (tx_a !== 1'b1 || tx_b !== 1'b1) txl++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) bsy++;
    end
    n_checks++; if (pops != 0) $display("FAIL empty_pops: got %0d want 0", pops); else n_pass++;
    n_checks++; if (txl != 0) $display("FAIL empty_tx: got %0d low cycles want 0", txl); else n_pass++;
    n_checks++; if (bsy != 0) $display("FAIL empty_busy: got %0d busy cycles want 0", bsy); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int pops0, stray = 0, e, target;
    pops0  = pops_a;
    target = FB*CD + 18;  // inside DATA bit 3 of byte 1
    push_a(32'h0BADF00D);
    wait_pop(1'b0, ok);
    n_checks++; if (!ok) begin $display("FAIL rst_pop: got no pop want pop within 50 cycles"); return; end else n_pass++;
    push_a(32'h5A3C96E1);
    for (int i = 1; i <= target; i++) begin
      @(negedge rd_clk);
      if (rd_en_a !== 1'b0 || done_a !== 1'b0) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL rst_mid_word_activity: got %0d want 0", stray); else n_pass++;
    n_checks++; if (tx_a !== 1'b0) $display("FAIL rst_pre_tx: got %b want 0", tx_a); else n_pass++;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    n_checks++; if (tx_a !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (rd_en_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_strobes: got rd_en=%b done=%b want 0 0", rd_en_a, done_a); else n_pass++;
    rd_rst = 1'b0;
    #1;
    n_checks++; if (rd_en_a !== 1'b1) $display("FAIL rst_release_pop: got %b want 1", rd_en_a); else n_pass++;
    record(1'b0, WORD_CYC + 2);
    build_exp(32'h5A3C96E1);
    e = stream_errs(0);
    n_checks++; if (e != 0) $display("FAIL rst_new_word: got %0d bad tx cycles want 0", e); else n_pass++;
    n_checks++; if (count_ones(0, 0, WORD_CYC + 1) != 1 || done_s[WORD_CYC-1] !== 1'b1)
      $display("FAIL rst_done: got pulses=%0d want 1 at word end", count_ones(0, 0, WORD_CYC + 1)); else n_pass++;
    n_checks++; if (pops_a - pops0 != 2) $display("FAIL rst_pop_count: got %0d want 2", pops_a - pops0); else n_pass++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    push_a(32'h00000307);
    push_a(32'h00000000);
    wait_pop(1'b0, ok);
    n_checks++; if (!ok) begin $display("FAIL par_pop: got no pop want pop within 50 cycles"); return; end else n_pass++;
    record(1'b0, 2*WORD_CYC + 2);
    n_checks++; if (tx_s[CD*9 + CD/2] !== 1'b1) $display("FAIL par_byte07: got %b want 1", tx_s[CD*9 + CD/2]); else n_pass++;
    n_checks++; if (tx_s[FB*CD + CD*9 + CD/2] !== 1'b0) $display("FAIL par_byte03: got %b want 0", tx_s[FB*CD + CD*9 + CD/2]); else n_pass++;
    n_checks++; if (pop_s[176] !== 1'b1 || count_ones(1, 0, 2*WORD_CYC + 1) != 1)
      $display("FAIL par_period: got pop@177=%b pops=%0d want 1 and 1", pop_s[176], count_ones(1, 0, 2*WORD_CYC + 1)); else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lsb_word();
    test_msb_word();
    test_back_to_back();
    test_empty_idle();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
